// File: rtl/cfglut_k.sv
// ============================================================================
// cfglut_k : runtime-reconfigurable K-input LUT, serially loaded truth table
// Revision : 1.0
// ============================================================================
`default_nettype none

module cfglut_k #(
  parameter int               K    = 5,
  parameter logic [2**K-1:0]  INIT = '0
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         CE,
  input  logic         CDI,
  input  logic [K-1:0] I,
  output logic         O,
  output logic         O_LO,
  output logic         CDO,
  output logic         CFG_DONE
);

  localparam int           N          = 2**K;
  localparam logic [K-1:0] c_cnt_last = K'(N - 1);
  localparam logic [K-1:0] c_cnt_one  = K'(1);

  generate
    if (K < 2 || K > 6) begin : g_bad_k
      $error("cfglut_k: K must be within 2..6");
    end
  endgenerate

  logic [N-1:0] cfg_q, cfg_d;
  logic [K-1:0] cnt_q, cnt_d;
  logic         done_q, done_d;

  // The done flag only rises on the shift that wraps the counter; CE gaps keep cnt.
  always_comb begin
    cfg_d  = cfg_q;
    cnt_d  = cnt_q;
    done_d = 1'b0;
    if (CE) begin
      cfg_d  = {cfg_q[N-2:0], CDI};
      cnt_d  = cnt_q + c_cnt_one;
      done_d = (cnt_q == c_cnt_last);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      cfg_q  <= INIT;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      cfg_q  <= cfg_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign O        = cfg_q[I];
  assign O_LO     = cfg_q[{1'b0, I[K-2:0]}];
  assign CDO      = cfg_q[N-1];
  assign CFG_DONE = done_q;

endmodule

`default_nettype wire

// File: tb/tb_cfglut_k.sv
// ============================================================================
// tb_cfglut_k : table-driven and randomised checks of cfglut_k for K = 2,4,5,6
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cfglut_k;

  localparam logic [31:0] INIT5 = 32'h8000_0000;
  localparam logic [3:0]  INIT2 = 4'b1011;
  localparam logic [63:0] INIT6 = 64'hC3A5_0F1E_9D24_7B68;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst5, ce5, cdi5;
  logic [4:0] i5;
  logic       o5, olo5, cdo5, done5;

  logic       rst4, ce4, cdi4;
  logic [3:0] i4;
  logic       o4a, olo4a, cdo4a, done4a, o4b, olo4b, cdo4b, done4b;

  logic       rstx, ce2, ce6, cdi2, cdi6;
  logic [1:0] i2;
  logic [5:0] i6;
  logic       o2, olo2, cdo2, done2, o6, olo6, cdo6, done6;

  cfglut_k #(.K(5), .INIT(INIT5)) u5 (
    .CLK(clk), .RST(rst5), .CE(ce5), .CDI(cdi5), .I(i5),
    .O(o5), .O_LO(olo5), .CDO(cdo5), .CFG_DONE(done5));

  cfglut_k #(.K(4), .INIT(16'h0000)) u4a (
    .CLK(clk), .RST(rst4), .CE(ce4), .CDI(cdi4), .I(i4),
    .O(o4a), .O_LO(olo4a), .CDO(cdo4a), .CFG_DONE(done4a));

  cfglut_k #(.K(4), .INIT(16'h0000)) u4b (
    .CLK(clk), .RST(rst4), .CE(ce4), .CDI(cdo4a), .I(i4),
    .O(o4b), .O_LO(olo4b), .CDO(cdo4b), .CFG_DONE(done4b));

  cfglut_k #(.K(2), .INIT(INIT2)) u2 (
    .CLK(clk), .RST(rstx), .CE(ce2), .CDI(cdi2), .I(i2),
    .O(o2), .O_LO(olo2), .CDO(cdo2), .CFG_DONE(done2));

  cfglut_k #(.K(6), .INIT(INIT6)) u6 (
    .CLK(clk), .RST(rstx), .CE(ce6), .CDI(cdi6), .I(i6),
    .O(o6), .O_LO(olo6), .CDO(cdo6), .CFG_DONE(done6));

  // Reference model state: truth table as a plain number plus a shift tally.
  logic [63:0] m5_cfg, m4a_cfg, m4b_cfg, m2_cfg, m6_cfg;
  int          m5_cnt, m4a_cnt, m4b_cnt, m2_cnt, m6_cnt;
  logic        m5_dn, m4a_dn, m4b_dn, m2_dn, m6_dn;

  int tests  = 0;
  int failed = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  task automatic mstep(input int n, input logic [63:0] init, input logic r, input logic c,
                       input logic d, inout logic [63:0] cfg, inout int cnt, inout logic dn);
    logic [63:0] mask;
    mask = (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    if (r) begin
      cfg = init; cnt = 0; dn = 1'b0;
    end else begin
      dn = 1'b0;
      if (c) begin
        cfg = ((cfg << 1) | {63'd0, d}) & mask;
        cnt = cnt + 1;
        if (cnt == n) begin
          cnt = 0;
          dn  = 1'b1;
        end
      end
    end
  endtask

  task automatic tick();
    logic cdi_b;
    @(posedge clk);
    cdi_b = m4a_cfg[15];
    mstep(32, {32'd0, INIT5}, rst5, ce5, cdi5, m5_cfg, m5_cnt, m5_dn);
    mstep(16, 64'd0, rst4, ce4, cdi4, m4a_cfg, m4a_cnt, m4a_dn);
    mstep(16, 64'd0, rst4, ce4, cdi_b, m4b_cfg, m4b_cnt, m4b_dn);
    mstep(4, {60'd0, INIT2}, rstx, ce2, cdi2, m2_cfg, m2_cnt, m2_dn);
    mstep(64, INIT6, rstx, ce6, cdi6, m6_cfg, m6_cnt, m6_dn);
    #1;
  endtask

  task automatic check_all();
    chk("u5.O", o5, m5_cfg[i5]);
    chk("u5.O_LO", olo5, m5_cfg[i5 % 16]);
    chk("u5.CDO", cdo5, m5_cfg[31]);
    chk("u5.DONE", done5, m5_dn);
    chk("u4a.O", o4a, m4a_cfg[i4]);
    chk("u4a.O_LO", olo4a, m4a_cfg[i4 % 8]);
    chk("u4a.DONE", done4a, m4a_dn);
    chk("u4b.O", o4b, m4b_cfg[i4]);
    chk("u4b.CDO", cdo4b, m4b_cfg[15]);
    chk("u4b.DONE", done4b, m4b_dn);
    chk("u2.O", o2, m2_cfg[i2]);
    chk("u2.O_LO", olo2, m2_cfg[i2 % 2]);
    chk("u2.DONE", done2, m2_dn);
    chk("u6.O", o6, m6_cfg[i6]);
    chk("u6.O_LO", olo6, m6_cfg[i6 % 32]);
    chk("u6.DONE", done6, m6_dn);
  endtask

  typedef struct {
    logic [4:0] i;
    logic       o;
    logic       o_lo;
  } vec_t;

  vec_t tbl[32];

  task automatic sweep5(input string nm);
    for (int k = 0; k < 32; k++) begin
      i5 = tbl[k].i;
      #1;
      chk({nm, ".O"}, o5, tbl[k].o);
      chk({nm, ".O_LO"}, olo5, tbl[k].o_lo);
    end
  endtask

  initial begin : main
    logic [31:0] w;
    logic [15:0] wa, wb;
    int pulses, pulse_at, ce_edges, pb;

    rst5 = 1; ce5 = 0; cdi5 = 0; i5 = 0;
    rst4 = 1; ce4 = 0; cdi4 = 0; i4 = 0;
    rstx = 1; ce2 = 0; ce6 = 0; cdi2 = 0; cdi6 = 0; i2 = 0; i6 = 0;
    tick();
    rst5 = 0; rst4 = 0; rstx = 0;
    check_all();

    // Reset contents of the K=5 table
    for (int k = 0; k < 32; k++) begin
      tbl[k].i = 5'(k); tbl[k].o = (k == 31); tbl[k].o_lo = 1'b0;
    end
    sweep5("t1");
    chk("t1.CDO", cdo5, 1'b1);
    chk("t1.DONE", done5, 1'b0);

    // Full 32-bit load, MSB first; CDO streams out the old table
    w = 32'hFFFF_0000;
    pulses = 0; pulse_at = -1;
    for (int s = 0; s < 32; s++) begin
      ce5 = 1; cdi5 = w[31-s]; i5 = 5'($urandom);
      #1;
      chk("t2.CDO_stream", cdo5, INIT5[31-s]);
      tick();
      check_all();
      if (done5) begin pulses++; pulse_at = s + 1; end
    end
    ce5 = 0;
    tick();
    check_all();
    chk("t2.pulses", 64'(pulses), 64'd1);
    chk("t2.pulse_at", 64'(pulse_at), 64'd32);
    for (int k = 0; k < 32; k++) begin
      tbl[k].i = 5'(k); tbl[k].o = k[4]; tbl[k].o_lo = 1'b0;
    end
    sweep5("t2");

    // Reset mid-load discards partial data and restarts the count
    for (int s = 0; s < 10; s++) begin
      ce5 = 1; cdi5 = 1'($urandom); tick(); check_all();
    end
    rst5 = 1; ce5 = 1;
    tick();
    rst5 = 0; ce5 = 0;
    check_all();
    chk("t3.DONE", done5, 1'b0);
    for (int k = 0; k < 32; k++) begin
      tbl[k].i = 5'(k); tbl[k].o = (k == 31); tbl[k].o_lo = 1'b0;
    end
    sweep5("t3.init");
    w = 32'h1234_5678;
    pulses = 0; pulse_at = -1;
    for (int s = 0; s < 32; s++) begin
      ce5 = 1; cdi5 = w[31-s];
      tick(); check_all();
      if (done5) begin pulses++; pulse_at = s + 1; end
    end
    ce5 = 0;
    chk("t3.pulses", 64'(pulses), 64'd1);
    chk("t3.pulse_at", 64'(pulse_at), 64'd32);
    for (int k = 0; k < 32; k++) begin
      tbl[k].i = 5'(k); tbl[k].o = w[k]; tbl[k].o_lo = w[k % 16];
    end
    sweep5("t3.load");

    // CE toggling every cycle
    w = 32'h6996_6996;
    pulses = 0; pulse_at = -1; ce_edges = 0;
    for (int c = 0; c < 64; c++) begin
      ce5 = (c % 2 == 0);
      cdi5 = ce5 ? w[31-ce_edges] : 1'($urandom);
      i5 = 5'($urandom);
      tick(); check_all();
      if (ce5) ce_edges++;
      if (done5) begin pulses++; pulse_at = ce_edges; end
    end
    ce5 = 0;
    tick(); check_all();
    chk("t4.pulses", 64'(pulses), 64'd1);
    chk("t4.pulse_at", 64'(pulse_at), 64'd32);
    for (int k = 0; k < 32; k++) begin
      tbl[k].i = 5'(k);
      tbl[k].o = k[0] ^ k[1] ^ k[2] ^ k[3];
      tbl[k].o_lo = tbl[k].o;
    end
    sweep5("t4");

    // Two-deep K=4 chain
    wa = 16'hAAAA; wb = 16'h00FF;
    pulses = 0; pb = 0;
    for (int s = 0; s < 32; s++) begin
      ce4 = 1; cdi4 = (s < 16) ? wa[15-s] : wb[31-s];
      i4 = 4'($urandom);
      tick(); check_all();
      if (done4a) begin
        pulses++;
        chk("t5.a_pulse_at", 64'((s + 1) % 16), 64'd0);
      end
      if (done4b) begin
        pb++;
        chk("t5.b_pulse_at", 64'((s + 1) % 16), 64'd0);
      end
    end
    ce4 = 0;
    chk("t5.a_pulses", 64'(pulses), 64'd2);
    chk("t5.b_pulses", 64'(pb), 64'd2);
    for (int k = 0; k < 16; k++) begin
      i4 = 4'(k);
      #1;
      chk("t5.first", o4a, wb[k]);
      chk("t5.second", o4b, wa[k]);
    end

    // K=2 and K=6 reset tables, then 3*N continuous shifts each
    for (int k = 0; k < 4; k++) begin
      i2 = 2'(k); #1;
      chk("t6.u2.O", o2, INIT2[k]);
      chk("t6.u2.O_LO", olo2, INIT2[k % 2]);
    end
    for (int k = 0; k < 64; k++) begin
      i6 = 6'(k); #1;
      chk("t6.u6.O", o6, INIT6[k]);
      chk("t6.u6.O_LO", olo6, INIT6[k % 32]);
    end
    pulses = 0; pb = 0;
    for (int s = 0; s < 192; s++) begin
      ce6 = 1; ce2 = (s < 12);
      cdi2 = 1'($urandom); cdi6 = 1'($urandom);
      i2 = 2'($urandom); i6 = 6'($urandom);
      tick(); check_all();
      if (done2) pulses++;
      if (done6) pb++;
    end
    ce2 = 0; ce6 = 0;
    tick(); check_all();
    chk("t6.u2.pulses", 64'(pulses), 64'd3);
    chk("t6.u6.pulses", 64'(pb), 64'd3);

    // Random traffic on every instance against the model
    for (int c = 0; c < 400; c++) begin
      rst5 = ($urandom_range(0, 39) == 0);
      rst4 = ($urandom_range(0, 39) == 0);
      rstx = ($urandom_range(0, 39) == 0);
      ce5 = 1'($urandom); ce4 = 1'($urandom); ce2 = 1'($urandom); ce6 = 1'($urandom);
      cdi5 = 1'($urandom); cdi4 = 1'($urandom); cdi2 = 1'($urandom); cdi6 = 1'($urandom);
      i5 = 5'($urandom); i4 = 4'($urandom); i2 = 2'($urandom); i6 = 6'($urandom);
      tick(); check_all();
    end

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
